reg_sb_ctrl: RTL and testbench
==============================

# reg_sb_ctrl

Register-file scoreboard and issue controller for the 15-entry (R0–R14) register file. It tracks outstanding write-backs per architectural register and holds the decode/issue stage until every source an instruction reads is free of pending writes. Each issue's destination is marked busy and cleared on retirement. It sits beside the register file at the ID/EX boundary and is the single authority on read-after-write hazards.

## Interface
- CNT_W, 2: width of each per-register pending counter (max in-flight writes per register = 2^CNT_W − 1)
- WB_BYPASS, 1: 1 = a write-back in the same cycle clears the hazard for that cycle (register file writes on the falling edge); 0 = hazard clears one cycle after write-back
- STAT_W, 16: width of the stall-cycle statistics counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction may issue; issue occurs when issue_valid && issue_ready
- src1, src2  in  4  source register indices
- src1_used, src2_used  in  1  corresponding source is actually read
- dest  in  4  destination register index
- dest_wen  in  1  instruction writes dest
- wb_en  in  1  a write-back retires this cycle
- wb_dest  in  4  register being written back
- flush  in  1  squash all in-flight instructions; clear all pending state
- busy_mask  out  15  bit i = R[i] has ≥1 pending write (registered)
- stall  out  1  issue_valid && !issue_ready
- err_underflow  out  1  sticky: write-back to a register with zero pending count
- stall_cycles  out  STAT_W  saturating count of cycles with stall high

## Operation
- Per register i in 0..14: counter cnt[i]; busy_mask[i] = (cnt[i] != 0).
- Index 15 (PC) is never tracked: src==15 never hazards; dest==15 or wb_dest==15 has no effect on any counter.
- Effective pending: eff[i] = cnt[i] − (WB_BYPASS && wb_en && wb_dest==i && cnt[i]!=0).
- Hazard when (src1_used && eff[src1]!=0) || (src2_used && eff[src2]!=0).
- Saturation block when dest_wen && dest!=15 && cnt[dest] == 2^CNT_W−1 && !(wb_en && wb_dest==dest).
- issue_ready = !hazard && !saturation block && !flush. It is combinational and independent of issue_valid.
- Counter update on each clock:
  - +1 on an issue that has dest_wen.
  - −1 on a write-back when cnt != 0.
  - Issue and write-back to the same register in the same cycle: net unchanged.
- Write-back with cnt[wb_dest]==0 (wb_dest!=15): counter stays 0; err_underflow set. It is cleared only by rst.
- flush: all cnt cleared next edge. Any issue or write-back in that cycle is ignored. The pipeline guarantees squashed instructions never assert wb_en.
- stall_cycles increments each cycle stall==1 and holds at all-ones.

## Timing
- Reset values (rst high at edge): all cnt=0, busy_mask=0, err_underflow=0, stall_cycles=0.
- While rst is high, issue_ready=0 (combinationally masked).
- Reset mid-operation discards all pending state; subsequent write-backs of pre-reset instructions count as underflow.
- issue_ready/stall: zero-latency combinational from inputs and current counters.
- busy_mask: updates one cycle after the issue or write-back edge.
- WB_BYPASS=1: a dependent instruction issues in the same cycle as its producer's write-back.
- WB_BYPASS=0: a dependent instruction issues one cycle after the producer's write-back.
- No internal FSM beyond the counters; throughput is 1 issue + 1 write-back per cycle.

## Structure
- Shared package reg_sb_pkg:
  - NUM_REGS=15, REG_IDX_W=4, PC_IDX=4'd15
  - typedef reg_idx_t (4-bit)
  - function is_tracked(idx) returning idx!=PC_IDX
- Sub-module sb_reg_counter, instantiated 15×, one per register.
  - Inputs: inc, dec, clr, rst.
  - Outputs: cnt, busy, saturated, underflow_pulse.
- Top level: hazard compare, saturation check, flush gating, error and statistics logic.

## Test plan
- Reset, then issue dest=R3 (dest_wen=1), next cycle src1=R3 → stall=1, busy_mask=0x0008. wb_en, wb_dest=3 → issue_ready=1 that same cycle (WB_BYPASS=1); busy_mask=0 next cycle.
- Three issues to R5 back-to-back, fourth issue to R5 (CNT_W=2) → saturation stall. Simultaneous wb to R5 → fourth issue accepted, cnt stays 3.
- src1=15, src2=15, dest=15 with wen, then wb_dest=15 → never stalls, busy_mask stays 0, err_underflow stays 0.
- wb_en with wb_dest=7 while cnt[7]=0 → err_underflow=1 and remains 1 until rst; cnt[7] stays 0.
- Pending writes on R1, R2, R4, then flush=1 with issue_valid=1 → issue_ready=0 that cycle; busy_mask=0 next cycle; next issue reading R1 proceeds.
- Hold a hazard for 5 cycles → stall_cycles=5. Apply rst mid-stall → stall_cycles=0, busy_mask=0, issue_ready=0 during rst.

Source files
------------

// File: rtl/reg_sb_pkg.sv
// Shared definitions for the register scoreboard: register count, index type,
// and the helper that separates tracked registers R0-R14 from the untracked PC.
// Purely declarative; no latency or backpressure of its own.
package reg_sb_pkg;

   localparam int NUM_REGS  = 15;
   localparam int REG_IDX_W = 4;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t PC_IDX = 4'd15;

   // R15 is the PC: it is never scoreboarded, so it can never hazard or count.
   function automatic logic is_tracked(input reg_idx_t idx);
      return idx != PC_IDX;
   endfunction

endpackage

// File: rtl/reg_sb_ctrl_if.sv
// Decode/issue, write-back and status bundle between the decode stage and the scoreboard.
// Latency: wires only. Backpressure: issue_ready is returned combinationally to decode.
// Ports: master = decode/retire side (drives issue + write-back), slave = scoreboard.
interface reg_sb_ctrl_if #(
   parameter int STAT_W = 16
);
   import reg_sb_pkg::*;

   // issue side
   logic                 issue_valid;
   logic                 issue_ready;
   reg_idx_t             src1;
   reg_idx_t             src2;
   logic                 src1_used;
   logic                 src2_used;
   reg_idx_t             dest;
   logic                 dest_wen;

   // retire side
   logic                 wb_en;
   reg_idx_t             wb_dest;
   logic                 flush;

   // status
   logic [NUM_REGS-1:0]  busy_mask;
   logic                 stall;
   logic                 err_underflow;
   logic [STAT_W-1:0]    stall_cycles;

   modport master (
      output issue_valid, src1, src2, src1_used, src2_used, dest, dest_wen,
      output wb_en, wb_dest, flush,
      input  issue_ready, busy_mask, stall, err_underflow, stall_cycles
   );

   modport slave (
      input  issue_valid, src1, src2, src1_used, src2_used, dest, dest_wen,
      input  wb_en, wb_dest, flush,
      output issue_ready, busy_mask, stall, err_underflow, stall_cycles
   );

endinterface

// File: rtl/sb_reg_counter.sv
// Pending write-back counter for one architectural register.
// Latency: cnt/busy update on the edge after inc/dec/clr; saturated and underflow_pulse are combinational.
// Backpressure: none internally; the owner must not raise a lone inc while saturated (it is held if it does).
// Ports: clk, rst (sync, active-high), inc (issue to this reg), dec (write-back to this reg),
//        clr (flush), cnt, busy (cnt!=0), saturated (cnt all-ones), underflow_pulse (dec at cnt==0).
module sb_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             saturated,
   output logic             underflow_pulse
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec) begin
         if (!saturated) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (dec && !inc) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (inc && dec && (cnt_q == '0)) begin
         // The write-back is bogus (nothing was pending) so it cannot cancel
         // the new issue; the issue is still counted.
         cnt_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt             = cnt_q;
   assign busy            = (cnt_q != '0);
   assign saturated       = &cnt_q;
   assign underflow_pulse = dec && !clr && (cnt_q == '0);

endmodule

// File: rtl/reg_sb_ctrl.sv
// Register-file scoreboard: holds issue until every read source has no pending write-back.
// Latency: issue_ready/stall are zero-cycle combinational; busy_mask, err_underflow, stall_cycles are registered.
// Backpressure: issue_ready drops on a RAW hazard, a saturated destination counter, flush, or rst.
// Ports: clk, rst (sync, active-high); sb (slave modport) carries issue, write-back, flush and status.
module reg_sb_ctrl
   import reg_sb_pkg::*;
#(
   parameter int CNT_W     = 2,
   parameter bit WB_BYPASS = 1'b1,
   parameter int STAT_W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   reg_sb_ctrl_if.slave sb
);

   logic [CNT_W-1:0]    cnt_w [NUM_REGS];
   logic [NUM_REGS-1:0] inc_w;
   logic [NUM_REGS-1:0] dec_w;
   logic [NUM_REGS-1:0] busy_w;
   logic [NUM_REGS-1:0] sat_w;
   logic [NUM_REGS-1:0] uflow_w;

   // 16-entry views so any 4-bit index (including the PC) can be looked up
   // directly; entry 15 is tied low so the PC never hazards or saturates.
   logic [15:0]         eff_busy;
   logic [15:0]         sat_ext;

   logic                hazard;
   logic                sat_block;
   logic                issue_fire;

   logic                err_q;
   logic                err_d;
   logic [STAT_W-1:0]   stall_cycles_q;
   logic [STAT_W-1:0]   stall_cycles_d;

   // ------------------------------------------------------------------
   // Per-register pending counters
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      // The PC never matches here because i stops at 14.
      assign inc_w[i] = issue_fire && sb.dest_wen && (sb.dest == reg_idx_t'(i));
      // Write-backs in a flush cycle are dropped along with everything else.
      assign dec_w[i] = sb.wb_en && !sb.flush && (sb.wb_dest == reg_idx_t'(i));

      sb_reg_counter #(
         .CNT_W           (CNT_W)
      ) u_cnt (
         .clk             (clk),
         .rst             (rst),
         .inc             (inc_w[i]),
         .dec             (dec_w[i]),
         .clr             (sb.flush),
         .cnt             (cnt_w[i]),
         .busy            (busy_w[i]),
         .saturated       (sat_w[i]),
         .underflow_pulse (uflow_w[i])
      );

      // With bypass, a write-back this cycle retires one pending write; the
      // register is only still pending if more than that one was outstanding.
      assign eff_busy[i] = busy_w[i] &&
                           !(WB_BYPASS && sb.wb_en && (sb.wb_dest == reg_idx_t'(i)) &&
                             (cnt_w[i] == CNT_W'(1)));
      assign sat_ext[i]  = sat_w[i];
   end

   assign eff_busy[15] = 1'b0;
   assign sat_ext[15]  = 1'b0;

   // ------------------------------------------------------------------
   // Issue decision
   // ------------------------------------------------------------------
   always_comb begin
      hazard    = (sb.src1_used && is_tracked(sb.src1) && eff_busy[sb.src1]) ||
                  (sb.src2_used && is_tracked(sb.src2) && eff_busy[sb.src2]);
      // A full counter can still accept a new writer if a write-back to the
      // same register frees a slot in the same cycle.
      sat_block = sb.dest_wen && is_tracked(sb.dest) && sat_ext[sb.dest] &&
                  !(sb.wb_en && (sb.wb_dest == sb.dest));
   end

   assign sb.issue_ready = !hazard && !sat_block && !sb.flush && !rst;
   assign issue_fire     = sb.issue_valid && sb.issue_ready;
   assign sb.stall       = sb.issue_valid && !sb.issue_ready;

   // ------------------------------------------------------------------
   // Sticky underflow error and stall statistics
   // ------------------------------------------------------------------
   always_comb begin
      err_d          = err_q | (|uflow_w);
      stall_cycles_d = stall_cycles_q;
      if (sb.stall && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q          <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         err_q          <= err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign sb.busy_mask     = busy_w;
   assign sb.err_underflow = err_q;
   assign sb.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_reg_sb_ctrl.sv
// Directed bench for reg_sb_ctrl (CNT_W=2, WB_BYPASS=1, STAT_W=16).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the following edge.
module tb_reg_sb_ctrl;
   import reg_sb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   reg_sb_ctrl_if #(.STAT_W(16)) sb_if ();

   reg_sb_ctrl #(
      .CNT_W     (2),
      .WB_BYPASS (1'b1),
      .STAT_W    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      sb_if.issue_valid = 1'b0;
      sb_if.src1        = 4'd0;
      sb_if.src2        = 4'd0;
      sb_if.src1_used   = 1'b0;
      sb_if.src2_used   = 1'b0;
      sb_if.dest        = 4'd0;
      sb_if.dest_wen    = 1'b0;
      sb_if.wb_en       = 1'b0;
      sb_if.wb_dest     = 4'd0;
      sb_if.flush       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // ---------------- reset ----------------
      idle();
      rst = 1'b1;
      sb_if.issue_valid = 1'b1;
      tick();
      tick();
      chk("rst_ready", {31'd0, sb_if.issue_ready}, 32'd0);
      chk("rst_busy", {17'd0, sb_if.busy_mask}, 32'd0);
      chk("rst_err", {31'd0, sb_if.err_underflow}, 32'd0);
      chk("rst_stat", {16'd0, sb_if.stall_cycles}, 32'd0);
      rst = 1'b0;
      idle();
      tick();

      // ---------------- RAW on R3 with bypass ----------------
      sb_if.issue_valid = 1'b1;
      sb_if.dest        = 4'd3;
      sb_if.dest_wen    = 1'b1;
      settle();
      chk("r3_issue_ready", {31'd0, sb_if.issue_ready}, 32'd1);
      tick();
      chk("r3_busy", {17'd0, sb_if.busy_mask}, 32'h0008);
      sb_if.dest_wen  = 1'b0;
      sb_if.src1      = 4'd3;
      sb_if.src1_used = 1'b1;
      settle();
      chk("r3_stall", {31'd0, sb_if.stall}, 32'd1);
      chk("r3_ready_low", {31'd0, sb_if.issue_ready}, 32'd0);
      sb_if.wb_en   = 1'b1;
      sb_if.wb_dest = 4'd3;
      settle();
      chk("r3_bypass_ready", {31'd0, sb_if.issue_ready}, 32'd1);
      chk("r3_bypass_stall", {31'd0, sb_if.stall}, 32'd0);
      tick();
      chk("r3_busy_clear", {17'd0, sb_if.busy_mask}, 32'd0);
      chk("r3_stat", {16'd0, sb_if.stall_cycles}, 32'd0);
      idle();

      // ---------------- saturation on R5 ----------------
      sb_if.issue_valid = 1'b1;
      sb_if.dest        = 4'd5;
      sb_if.dest_wen    = 1'b1;
      tick();
      tick();
      tick();
      chk("r5_busy", {17'd0, sb_if.busy_mask}, 32'h0020);
      settle();
      chk("r5_sat_ready", {31'd0, sb_if.issue_ready}, 32'd0);
      chk("r5_sat_stall", {31'd0, sb_if.stall}, 32'd1);
      sb_if.wb_en   = 1'b1;
      sb_if.wb_dest = 4'd5;
      settle();
      chk("r5_sat_wb_ready", {31'd0, sb_if.issue_ready}, 32'd1);
      tick();
      // counter should still be 3: takes exactly three write-backs to drain
      sb_if.issue_valid = 1'b0;
      sb_if.dest_wen    = 1'b0;
      tick();
      chk("r5_drain1", {17'd0, sb_if.busy_mask}, 32'h0020);
      tick();
      chk("r5_drain2", {17'd0, sb_if.busy_mask}, 32'h0020);
      tick();
      chk("r5_drain3", {17'd0, sb_if.busy_mask}, 32'd0);
      chk("r5_err", {31'd0, sb_if.err_underflow}, 32'd0);
      idle();

      // ---------------- PC (R15) is never tracked ----------------
      sb_if.issue_valid = 1'b1;
      sb_if.src1        = 4'd15;
      sb_if.src2        = 4'd15;
      sb_if.src1_used   = 1'b1;
      sb_if.src2_used   = 1'b1;
      sb_if.dest        = 4'd15;
      sb_if.dest_wen    = 1'b1;
      settle();
      chk("pc_ready1", {31'd0, sb_if.issue_ready}, 32'd1);
      tick();
      chk("pc_busy1", {17'd0, sb_if.busy_mask}, 32'd0);
      sb_if.wb_en   = 1'b1;
      sb_if.wb_dest = 4'd15;
      settle();
      chk("pc_ready2", {31'd0, sb_if.issue_ready}, 32'd1);
      tick();
      chk("pc_busy2", {17'd0, sb_if.busy_mask}, 32'd0);
      chk("pc_err", {31'd0, sb_if.err_underflow}, 32'd0);
      idle();

      // ---------------- stall counting, then reset mid-stall ----------------
      sb_if.issue_valid = 1'b1;
      sb_if.dest        = 4'd9;
      sb_if.dest_wen    = 1'b1;
      tick();
      chk("r9_busy", {17'd0, sb_if.busy_mask}, 32'h0200);
      sb_if.dest_wen  = 1'b0;
      sb_if.src1      = 4'd9;
      sb_if.src1_used = 1'b1;
      settle();
      chk("r9_stall", {31'd0, sb_if.stall}, 32'd1);
      for (int k = 0; k < 5; k++) tick();
      chk("r9_stat5", {16'd0, sb_if.stall_cycles}, 32'd5);
      chk("r9_busy_held", {17'd0, sb_if.busy_mask}, 32'h0200);
      rst = 1'b1;
      settle();
      chk("midrst_ready", {31'd0, sb_if.issue_ready}, 32'd0);
      tick();
      chk("midrst_stat", {16'd0, sb_if.stall_cycles}, 32'd0);
      chk("midrst_busy", {17'd0, sb_if.busy_mask}, 32'd0);
      rst = 1'b0;
      idle();
      tick();

      // ---------------- flush ----------------
      sb_if.issue_valid = 1'b1;
      sb_if.dest_wen    = 1'b1;
      sb_if.dest        = 4'd1;
      tick();
      sb_if.dest        = 4'd2;
      tick();
      sb_if.dest        = 4'd4;
      tick();
      chk("fl_busy", {17'd0, sb_if.busy_mask}, 32'h0016);
      sb_if.dest_wen  = 1'b0;
      sb_if.dest      = 4'd0;
      sb_if.src1      = 4'd1;
      sb_if.src1_used = 1'b1;
      sb_if.flush     = 1'b1;
      sb_if.wb_en     = 1'b1;   // write-back in a flush cycle must be ignored
      sb_if.wb_dest   = 4'd7;
      settle();
      chk("fl_ready", {31'd0, sb_if.issue_ready}, 32'd0);
      tick();
      chk("fl_busy_clear", {17'd0, sb_if.busy_mask}, 32'd0);
      chk("fl_err", {31'd0, sb_if.err_underflow}, 32'd0);
      sb_if.flush = 1'b0;
      sb_if.wb_en = 1'b0;
      settle();
      chk("fl_after_ready", {31'd0, sb_if.issue_ready}, 32'd1);
      chk("fl_stat", {16'd0, sb_if.stall_cycles}, 32'd1);
      tick();
      idle();

      // ---------------- underflow on R7 ----------------
      sb_if.wb_en   = 1'b1;
      sb_if.wb_dest = 4'd7;
      tick();
      idle();
      chk("uf_err", {31'd0, sb_if.err_underflow}, 32'd1);
      chk("uf_busy", {17'd0, sb_if.busy_mask}, 32'd0);
      tick();
      tick();
      tick();
      chk("uf_err_sticky", {31'd0, sb_if.err_underflow}, 32'd1);
      sb_if.issue_valid = 1'b1;
      sb_if.dest        = 4'd7;
      sb_if.dest_wen    = 1'b1;
      tick();
      chk("uf_r7_busy", {17'd0, sb_if.busy_mask}, 32'h0080);
      idle();
      sb_if.wb_en   = 1'b1;
      sb_if.wb_dest = 4'd7;
      tick();
      chk("uf_r7_clear", {17'd0, sb_if.busy_mask}, 32'd0);
      idle();
      rst = 1'b1;
      tick();
      chk("uf_rst_clear", {31'd0, sb_if.err_underflow}, 32'd0);
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
